// File: rtl/instr_mem_loadable.sv
// Synchronous-read instruction memory with a one-cycle fetch handshake and a
// byte-serial run-time loader that assembles little-endian words into the array.
module instr_mem_loadable #(
   parameter int               WIDTH     = 32,
   parameter int               MEM_DEPTH = 256,
   parameter logic [WIDTH-1:0] NOP_INSTR = 32'h00000013,
   parameter int               CNT_W     = $clog2(MEM_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fetch_req,
   input  logic [WIDTH-1:0] fetch_addr,
   output logic             fetch_ready,
   output logic             instr_valid,
   output logic [WIDTH-1:0] instruction,
   output logic             instr_fault,
   input  logic             load_en,
   input  logic             load_byte_valid,
   input  logic [7:0]       load_byte,
   output logic             load_busy,
   output logic             load_done,
   output logic [CNT_W-1:0] load_count,
   output logic             load_ovf
);

   localparam int              AW       = $clog2(MEM_DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MEM_DEPTH);

   typedef enum logic [1:0] {RUN, LOAD, FINISH} state_t;

   state_t           state, state_nxt;
   logic [1:0]       byte_cnt;
   logic [CNT_W-1:0] wr_ptr;
   logic [23:0]      asm_word;
   logic             ovf;
   logic             mem_full;
   logic             mem_we;
   logic [WIDTH-1:0] mem_wdata;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] mem [MEM_DEPTH];

   logic             accept;
   logic             in_range;
   logic             misaligned;
   logic [WIDTH-1:0] rd_data_p1;
   logic             vld_p1;
   logic             sel_mem_p1;
   logic             fault_p1;

   // Lanes beyond the bytes received are forced to zero.
   function automatic logic [WIDTH-1:0] partial_word(input logic [23:0] lanes,
                                                     input logic [1:0]  n);
      case (n)
         2'd1:    return {24'h000000, lanes[7:0]};
         2'd2:    return {16'h0000, lanes[15:0]};
         2'd3:    return {8'h00, lanes};
         default: return '0;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (load_en) state_nxt = LOAD;
         LOAD:    if (!load_en) state_nxt = FINISH;
         FINISH:  state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   assign fetch_ready = (state == RUN);
   assign load_busy   = (state != RUN);
   assign load_done   = (state == FINISH);
   assign load_count  = wr_ptr;
   assign load_ovf    = ovf;
   assign mem_full    = (wr_ptr == FULL_CNT);
   assign waddr       = wr_ptr[AW-1:0];

   always_comb begin
      mem_we    = 1'b0;
      mem_wdata = {load_byte, asm_word};
      if (state == LOAD && load_byte_valid && !mem_full && byte_cnt == 2'd3) begin
         mem_we = 1'b1;
      end else if (state == FINISH && byte_cnt != 2'd0 && !mem_full) begin
         mem_we    = 1'b1;
         mem_wdata = partial_word(asm_word, byte_cnt);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt <= 2'd0;
         wr_ptr   <= '0;
         asm_word <= 24'h000000;
         ovf      <= 1'b0;
      end else if (state == RUN && load_en) begin
         byte_cnt <= 2'd0;
         wr_ptr   <= '0;
         ovf      <= 1'b0;
      end else begin
         if (state == LOAD && load_byte_valid) begin
            if (mem_full) begin
               ovf <= 1'b1;
            end else begin
               byte_cnt <= byte_cnt + 2'd1;
               case (byte_cnt)
                  2'd0:    asm_word[7:0]   <= load_byte;
                  2'd1:    asm_word[15:8]  <= load_byte;
                  2'd2:    asm_word[23:16] <= load_byte;
                  default: ;
               endcase
            end
         end
         if (mem_we) wr_ptr <= wr_ptr + CNT_W'(1);
      end
   end

   // Fetch request stage -> response stage (p1)
   assign accept     = fetch_req & fetch_ready;
   assign misaligned = |fetch_addr[1:0];
   assign in_range   = (fetch_addr[WIDTH-1:AW+2] == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1     <= 1'b0;
         sel_mem_p1 <= 1'b0;
         fault_p1   <= 1'b0;
      end else begin
         vld_p1 <= accept;
         if (accept) begin
            sel_mem_p1 <= in_range & ~misaligned;
            fault_p1   <= misaligned;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[waddr] <= mem_wdata;
      if (accept) rd_data_p1 <= mem[fetch_addr[AW+1:2]];
   end

   assign instr_valid = vld_p1;
   assign instr_fault = fault_p1;
   assign instruction = sel_mem_p1 ? rd_data_p1 : NOP_INSTR;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: directed table vectors, hand-written load/reset
// sequences and randomized sessions checked against an array-based model.
module tb_instr_mem_loadable;

   localparam int          MEM_DEPTH = 256;
   localparam int          CNT_W     = 9;
   localparam logic [31:0] NOP       = 32'h00000013;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             fetch_req = 1'b0;
   logic [31:0]      fetch_addr = '0;
   logic             fetch_ready;
   logic             instr_valid;
   logic [31:0]      instruction;
   logic             instr_fault;
   logic             load_en = 1'b0;
   logic             load_byte_valid = 1'b0;
   logic [7:0]       load_byte = '0;
   logic             load_busy;
   logic             load_done;
   logic [CNT_W-1:0] load_count;
   logic             load_ovf;

   instr_mem_loadable #(
      .WIDTH(32), .MEM_DEPTH(MEM_DEPTH), .NOP_INSTR(NOP), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
      .instr_valid(instr_valid), .instruction(instruction), .instr_fault(instr_fault),
      .load_en(load_en), .load_byte_valid(load_byte_valid), .load_byte(load_byte),
      .load_busy(load_busy), .load_done(load_done), .load_count(load_count),
      .load_ovf(load_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      logic        fault;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] mdl [MEM_DEPTH];
   logic [7:0]  lb [$];
   logic [31:0] fq [$];
   vec_t        tbl [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_instr(input logic [31:0] a);
      if (a[1:0] != 2'b00) return NOP;
      if (a[31:10] != '0) return NOP;
      return mdl[a[9:2]];
   endfunction

   // Model: byte i of a session lands in lane i%4 of word i/4; the last word is zero-padded.
   task automatic model_load(input int n, output int cnt, output logic ovf);
      for (int i = 0; i < n; i++) begin
         if (i / 4 < MEM_DEPTH) begin
            if (i % 4 == 0) mdl[i / 4] = '0;
            mdl[i / 4][8 * (i % 4) +: 8] = lb[i];
         end
      end
      cnt = (n + 3) / 4;
      if (cnt > MEM_DEPTH) cnt = MEM_DEPTH;
      ovf = (n > 4 * MEM_DEPTH);
   endtask

   task automatic do_load(input int n, input bit exit_with_last, input bit gaps);
      int   cnt;
      logic ovf;
      load_en         = 1'b1;
      load_byte_valid = 1'($urandom_range(0, 1));
      load_byte       = 8'hee;
      fetch_req       = 1'b0;
      tick();
      chk("entry_busy", load_busy, 1);
      chk("entry_ready", fetch_ready, 0);
      chk("entry_count", load_count, 0);
      chk("entry_ovf", load_ovf, 0);
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            load_byte_valid = 1'b0;
            fetch_req       = 1'b1;
            fetch_addr      = 32'h0;
            tick();
            chk("load_nofetch", instr_valid, 0);
         end
         load_byte_valid = 1'b1;
         load_byte       = lb[i];
         load_en         = !(exit_with_last && i == n - 1);
         fetch_req       = 1'($urandom_range(0, 1));
         tick();
         if (n < 64 || i % 64 == 0) chk("load_nofetch", instr_valid, 0);
      end
      fetch_req = 1'b0;
      if (!(exit_with_last && n > 0)) begin
         load_byte_valid = 1'b0;
         load_en         = 1'b0;
         tick();
      end
      load_byte_valid = 1'b0;
      load_en         = 1'b0;
      chk("finish_done", load_done, 1);
      chk("finish_busy", load_busy, 1);
      model_load(n, cnt, ovf);
      tick();
      chk("post_done", load_done, 0);
      chk("post_busy", load_busy, 0);
      chk("post_ready", fetch_ready, 1);
      chk("load_count", load_count, cnt);
      chk("load_ovf", load_ovf, ovf);
   endtask

   task automatic fetch_burst();
      logic [31:0] last;
      last = NOP;
      foreach (fq[i]) begin
         fetch_req  = 1'b1;
         fetch_addr = fq[i];
         tick();
         last = exp_instr(fq[i]);
         chk("fetch_valid", instr_valid, 1);
         chk("fetch_instr", instruction, last);
         chk("fetch_fault", instr_fault, (fq[i][1:0] != 2'b00));
      end
      fetch_req = 1'b0;
      tick();
      chk("idle_valid", instr_valid, 0);
      if (fq.size() > 0) chk("idle_hold", instruction, last);
   endtask

   initial begin
      int   r;
      int   n;
      logic [31:0] a;

      // reset state
      #2 rst = 1'b1;
      tick();
      tick();
      chk("rst_ready", fetch_ready, 1);
      chk("rst_valid", instr_valid, 0);
      chk("rst_instr", instruction, NOP);
      chk("rst_fault", instr_fault, 0);
      chk("rst_busy", load_busy, 0);
      chk("rst_done", load_done, 0);
      chk("rst_count", load_count, 0);
      chk("rst_ovf", load_ovf, 0);
      @(negedge clk) rst = 1'b0;

      // fetch before any load: contents unknown, handshake and range checked
      fetch_req  = 1'b1;
      fetch_addr = 32'h0;
      tick();
      chk("unloaded_valid", instr_valid, 1);
      chk("unloaded_fault", instr_fault, 0);
      fetch_addr = 32'h400;
      tick();
      chk("oor_valid", instr_valid, 1);
      chk("oor_instr", instruction, NOP);
      chk("oor_fault", instr_fault, 0);
      fetch_req = 1'b0;
      tick();
      chk("oor_idle", instr_valid, 0);

      // two-word program, then table of back-to-back fetches
      lb = '{8'h93, 8'h00, 8'ha0, 8'h01, 8'ha3, 8'h20, 8'h10, 8'h50};
      do_load(8, 1'b0, 1'b0);
      tbl[0] = '{32'h0,        32'h01a00093, 1'b0};
      tbl[1] = '{32'h4,        32'h501020a3, 1'b0};
      tbl[2] = '{32'h6,        NOP,          1'b1};
      tbl[3] = '{32'h400,      NOP,          1'b0};
      tbl[4] = '{32'hfffffffc, NOP,          1'b0};
      tbl[5] = '{32'h3fd,      NOP,          1'b1};
      for (int i = 0; i < 6; i++) begin
         fetch_req  = 1'b1;
         fetch_addr = tbl[i].addr;
         tick();
         chk("tbl_valid", instr_valid, 1);
         chk("tbl_instr", instruction, tbl[i].instr);
         chk("tbl_fault", instr_fault, tbl[i].fault);
      end
      fetch_req = 1'b0;
      tick();

      // partial final word, last byte arriving with load_en low
      lb = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hff};
      do_load(5, 1'b1, 1'b0);
      chk("partial_model", mdl[1], 32'h000000ff);
      fq = '{32'h0, 32'h4, 32'h6};
      fetch_burst();

      // reset after 6 bytes of a session
      lb.delete();
      for (int i = 0; i < 6; i++) lb.push_back(8'($urandom));
      load_en = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         load_byte_valid = 1'b1;
         load_byte       = lb[i];
         tick();
      end
      #2;
      rst             = 1'b1;
      load_en         = 1'b0;
      load_byte_valid = 1'b0;
      #1;
      chk("abort_ready", fetch_ready, 1);
      chk("abort_busy", load_busy, 0);
      chk("abort_done", load_done, 0);
      @(negedge clk) rst = 1'b0;
      mdl[0] = {lb[3], lb[2], lb[1], lb[0]};
      tick();
      chk("abort_nodone", load_done, 0);
      fq = '{32'h0, 32'h4};
      fetch_burst();

      // fill the whole array, then 4 bytes of overflow
      lb.delete();
      for (int i = 0; i < 4 * MEM_DEPTH + 4; i++) lb.push_back(8'($urandom));
      do_load(4 * MEM_DEPTH + 4, 1'b0, 1'b0);
      fq = '{32'h0, 32'h3fc, 32'h8};
      fetch_burst();

      // load_en together with a fetch: response still delivered, later fetches ignored
      fetch_req  = 1'b1;
      fetch_addr = 32'h8;
      load_en    = 1'b1;
      tick();
      chk("same_valid", instr_valid, 1);
      chk("same_instr", instruction, mdl[2]);
      chk("same_ready", fetch_ready, 0);
      fetch_addr = 32'h0;
      tick();
      chk("inload_valid", instr_valid, 0);
      chk("inload_ovf_clr", load_ovf, 0);
      load_en = 1'b0;
      tick();
      chk("inload_valid2", instr_valid, 0);
      chk("empty_done", load_done, 1);
      fetch_req = 1'b0;
      tick();
      chk("empty_count", load_count, 0);
      chk("empty_busy", load_busy, 0);

      // randomized sessions and fetch bursts
      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 1) == 1) begin
            n = $urandom_range(0, 24);
            lb.delete();
            for (int i = 0; i < n; i++) lb.push_back(8'($urandom));
            do_load(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end else begin
            fq.delete();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
               r = $urandom_range(0, 9);
               if (r < 7)       a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
               else if (r == 7) a = {22'h0, 8'($urandom), 2'($urandom_range(1, 3))};
               else if (r == 8) a = {20'($urandom_range(1, 1048575)), 10'($urandom), 2'b00};
               else             a = $urandom;
               fq.push_back(a);
            end
            fetch_burst();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
